// File: rtl/hazard_ctrl_unit.sv
// Hazard and sequencing controller for a 5-stage IF/ID/EX/DM/WB pipeline:
// stalls, bubbles, flushes, PC select, EX forwarding and saturating perf counters.
module hazard_ctrl_unit #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       dm_rd,
    input  logic             dm_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dm_access,
    input  logic             jump_id,
    input  logic             branch_taken_dm,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             stall_all,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_dm,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_FLUSH    = 2'b11
    } state_t;

    // The dm_access cycle itself is the first stall; MEM_WAIT covers the rest.
    localparam bit         MEM_MULTI = (MEM_LAT > 1);
    localparam bit         USE_WAIT  = (MEM_LAT > 2);
    localparam logic [3:0] WAIT_INIT = USE_WAIT ? 4'(MEM_LAT - 2) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush_evt;
    logic [1:0][4:0]  fwd_src;
    logic [1:0][1:0]  fwd_sel;

    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        stall_all    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_dm  = 1'b0;
        pc_sel       = 2'b00;
        flush_evt    = 1'b0;
        if (state_q == ST_MEM_WAIT) begin
            // DM is frozen, so a branch resolution here is stale and ignored.
            stall_all = 1'b1;
            if (wait_q <= 4'd1) begin
                state_d = ST_RUN;
                wait_d  = 4'd0;
            end else begin
                wait_d = wait_q - 4'd1;
            end
        end else if (branch_taken_dm) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_ex_dm = 1'b1;
            pc_sel      = 2'b10;
            flush_evt   = 1'b1;
            state_d     = ST_FLUSH;
        end else if (MEM_MULTI && dm_access) begin
            stall_all = 1'b1;
            state_d   = USE_WAIT ? ST_MEM_WAIT : ST_RUN;
            wait_d    = WAIT_INIT;
        end else if (load_use && (state_q == ST_RUN)) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            state_d      = ST_LD_STALL;
        end else if (jump_id && (state_q != ST_FLUSH)) begin
            pc_sel      = 2'b01;
            flush_if_id = 1'b1;
            flush_evt   = 1'b1;
            state_d     = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    assign fwd_src[0] = ex_rs;
    assign fwd_src[1] = ex_rt;

    // DM result is younger than WB data, so it wins when both match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            stall_all ? 2'b00 :
            (dm_reg_write && (dm_rd != 5'd0) && (dm_rd == fwd_src[gi])) ? 2'b01 :
            (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == fwd_src[gi])) ? 2'b10 :
            2'b00;
    end

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_pc || stall_all) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (MEM_LAT=3 and 4) checked each cycle
// against a behavioural model, plus hand-computed pins at key points.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, dm_rd, wb_rd;
    logic       id_uses_rt, ex_reg_write, ex_mem_read, dm_reg_write, wb_reg_write;
    logic       dm_access, jump_id, branch_taken_dm;

    logic        stall_pc_a, stall_if_id_a, bubble_id_ex_a, stall_all_a;
    logic        flush_if_id_a, flush_id_ex_a, flush_ex_dm_a;
    logic [1:0]  pc_sel_a, fwd_a_a, fwd_b_a, ctrl_state_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        stall_pc_b, stall_if_id_b, bubble_id_ex_b, stall_all_b;
    logic        flush_if_id_b, flush_id_ex_b, flush_ex_dm_b;
    logic [1:0]  pc_sel_b, fwd_a_b, fwd_b_b, ctrl_state_b;
    logic [15:0] stall_cnt_b, flush_cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.MEM_LAT(3), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .dm_rd(dm_rd), .dm_reg_write(dm_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .dm_access(dm_access), .jump_id(jump_id), .branch_taken_dm(branch_taken_dm),
        .stall_pc(stall_pc_a), .stall_if_id(stall_if_id_a), .bubble_id_ex(bubble_id_ex_a),
        .stall_all(stall_all_a), .flush_if_id(flush_if_id_a), .flush_id_ex(flush_id_ex_a),
        .flush_ex_dm(flush_ex_dm_a), .pc_sel(pc_sel_a), .fwd_a(fwd_a_a), .fwd_b(fwd_b_a),
        .ctrl_state(ctrl_state_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl_unit #(.MEM_LAT(4), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .dm_rd(dm_rd), .dm_reg_write(dm_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .dm_access(dm_access), .jump_id(jump_id), .branch_taken_dm(branch_taken_dm),
        .stall_pc(stall_pc_b), .stall_if_id(stall_if_id_b), .bubble_id_ex(bubble_id_ex_b),
        .stall_all(stall_all_b), .flush_if_id(flush_if_id_b), .flush_id_ex(flush_id_ex_b),
        .flush_ex_dm(flush_ex_dm_b), .pc_sel(pc_sel_b), .fwd_a(fwd_a_b), .fwd_b(fwd_b_b),
        .ctrl_state(ctrl_state_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    logic [46:0] obs_a, obs_b;
    assign obs_a = {stall_pc_a, stall_if_id_a, bubble_id_ex_a, stall_all_a, flush_if_id_a,
                    flush_id_ex_a, flush_ex_dm_a, pc_sel_a, fwd_a_a, fwd_b_a, ctrl_state_a,
                    stall_cnt_a, flush_cnt_a};
    assign obs_b = {stall_pc_b, stall_if_id_b, bubble_id_ex_b, stall_all_b, flush_if_id_b,
                    flush_id_ex_b, flush_ex_dm_b, pc_sel_b, fwd_a_b, fwd_b_b, ctrl_state_b,
                    stall_cnt_b, flush_cnt_b};

    // Model: count remaining memory-stall cycles and remember last cycle's event.
    int lat[2] = '{3, 4};
    int mem_left[2], scnt[2], fcnt[2];
    bit after_flush[2], after_ld[2];
    int mem_left_n[2], scnt_n[2], fcnt_n[2];
    bit after_flush_n[2], after_ld_n[2];

    function automatic logic [1:0] m_fwd(input logic [4:0] x);
        if (dm_reg_write && dm_rd != 0 && dm_rd == x) return 2'd1;
        if (wb_reg_write && wb_rd != 0 && wb_rd == x) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_eval(input int i, output logic [46:0] exp);
        logic sp, sa, f1, f2, f3, lu, fl;
        logic [1:0] pcs, fa, fb, cs;
        sp = 0; sa = 0; f1 = 0; f2 = 0; f3 = 0; fl = 0; pcs = 0;
        cs = (mem_left[i] > 0) ? 2'd2 : after_flush[i] ? 2'd3 : after_ld[i] ? 2'd1 : 2'd0;
        lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        mem_left_n[i] = 0; after_flush_n[i] = 0; after_ld_n[i] = 0;
        if (mem_left[i] > 0) begin
            sa = 1; mem_left_n[i] = mem_left[i] - 1;
        end else if (branch_taken_dm) begin
            f1 = 1; f2 = 1; f3 = 1; pcs = 2'd2; fl = 1; after_flush_n[i] = 1;
        end else if (dm_access && lat[i] > 1) begin
            sa = 1; mem_left_n[i] = lat[i] - 2;
        end else if (lu && !after_flush[i] && !after_ld[i]) begin
            sp = 1; after_ld_n[i] = 1;
        end else if (jump_id && !after_flush[i]) begin
            f1 = 1; pcs = 2'd1; fl = 1;
        end
        fa = sa ? 2'd0 : m_fwd(ex_rs);
        fb = sa ? 2'd0 : m_fwd(ex_rt);
        scnt_n[i] = ((sp || sa) && scnt[i] < 65535) ? scnt[i] + 1 : scnt[i];
        fcnt_n[i] = (fl && fcnt[i] < 65535) ? fcnt[i] + 1 : fcnt[i];
        exp = {sp, sp, sp, sa, f1, f2, f3, pcs, fa, fb, cs, 16'(scnt[i]), 16'(fcnt[i])};
    endtask

    always @(negedge clk) begin
        logic [46:0] exp, act;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                model_eval(i, exp);
                act = (i == 0) ? obs_a : obs_b;
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL model_cycle inst=%0d t=%0t got=%h required=%h", i, $time, act, exp);
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mem_left[i] <= 0; scnt[i] <= 0; fcnt[i] <= 0;
                after_flush[i] <= 0; after_ld[i] <= 0;
            end else begin
                mem_left[i] <= mem_left_n[i]; scnt[i] <= scnt_n[i]; fcnt[i] <= fcnt_n[i];
                after_flush[i] <= after_flush_n[i]; after_ld[i] <= after_ld_n[i];
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_reg_write = 0; ex_mem_read = 0; dm_rd = 0; dm_reg_write = 0;
        wb_rd = 0; wb_reg_write = 0; dm_access = 0; jump_id = 0; branch_taken_dm = 0;
    endtask

    task automatic nc();
        @(posedge clk); #1;
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd; id_rs = rs;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; nc(); rst_n = 1;
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        ne();
        pin("reset_state", {30'd0, ctrl_state_a}, 32'd0);
        pin("reset_cnts", {stall_cnt_a, flush_cnt_a}, 32'd0);
        pin("reset_ctrl", {25'd0, obs_a[46:40]}, 32'd0);
        $display("txn reset_release");

        nc(); set_lu(5'd5, 5'd5); ne();
        pin("lu_stall", {29'd0, stall_pc_a, stall_if_id_a, bubble_id_ex_a}, 32'd7);
        nc(); idle(); ne();
        pin("lu_state", {30'd0, ctrl_state_a}, 32'd1);
        pin("lu_cnt", {16'd0, stall_cnt_a}, 32'd1);
        pin("lu_once", {31'd0, stall_pc_a}, 32'd0);
        nc(); set_lu(5'd0, 5'd0); ne();
        pin("lu_r0", {31'd0, stall_pc_a}, 32'd0);
        pin("lu_r0_state", {30'd0, ctrl_state_a}, 32'd0);
        $display("txn load_use");

        nc(); idle(); set_lu(5'd5, 5'd5); jump_id = 1; branch_taken_dm = 1; ne();
        pin("br_flush", {29'd0, flush_if_id_a, flush_id_ex_a, flush_ex_dm_a}, 32'd7);
        pin("br_pcsel", {30'd0, pc_sel_a}, 32'd2);
        pin("br_nostall", {31'd0, stall_pc_a}, 32'd0);
        nc(); branch_taken_dm = 0; ne();
        pin("flush_state", {30'd0, ctrl_state_a}, 32'd3);
        pin("flush_mask", {29'd0, stall_pc_a, pc_sel_a}, 32'd0);
        pin("flush_cnt1", {16'd0, flush_cnt_a}, 32'd1);
        nc(); ne();
        pin("lu_over_jump", {29'd0, stall_pc_a, pc_sel_a}, 32'd4);
        nc(); set_lu(5'd0, 5'd0); ex_mem_read = 0; ne();
        pin("jump_deferred", {29'd0, flush_if_id_a, pc_sel_a}, 32'd5);
        nc(); idle(); ne();
        pin("cnts_after_jump", {stall_cnt_a, flush_cnt_a}, {16'd2, 16'd2});
        $display("txn branch_jump");

        do_reset(); dm_access = 1; ne();
        pin("mem_first", {29'd0, stall_all_a, ctrl_state_a}, 32'd4);
        nc(); dm_access = 0; branch_taken_dm = 1; ne();
        pin("mem_wait_a", {29'd0, stall_all_a, ctrl_state_a}, 32'd6);
        pin("mem_br_ignored", {29'd0, flush_ex_dm_a, pc_sel_a}, 32'd0);
        nc(); branch_taken_dm = 0; ne();
        pin("mem_done_a", {29'd0, stall_all_a, ctrl_state_a}, 32'd0);
        pin("mem_cnt_a", {stall_cnt_a, flush_cnt_a}, {16'd2, 16'd0});
        pin("mem_wait_b", {29'd0, stall_all_b, ctrl_state_b}, 32'd6);
        nc(); ne();
        pin("mem_cnt_b", {14'd0, ctrl_state_b, stall_cnt_b}, 32'd3);
        $display("txn mem_wait");

        nc(); dm_access = 1; nc(); dm_access = 0; ne();
        pin("rst_mid_pre", {30'd0, ctrl_state_b}, 32'd2);
        #2 rst_n = 0;
        nc(); rst_n = 1; ne();
        pin("rst_mid_b", {obs_b[46:32], obs_b[31:0]} == 47'd0 ? 32'd0 : 32'd1, 32'd0);
        pin("rst_mid_cnt", {stall_cnt_b, flush_cnt_b}, 32'd0);
        $display("txn reset_mid_wait");

        nc(); ex_rs = 7; dm_rd = 7; wb_rd = 7; dm_reg_write = 1; wb_reg_write = 1; ne();
        pin("fwd_dm", {30'd0, fwd_a_a}, 32'd1);
        nc(); dm_reg_write = 0; ne();
        pin("fwd_wb", {30'd0, fwd_a_a}, 32'd2);
        nc(); ex_rs = 0; ex_rt = 0; wb_rd = 0; ne();
        pin("fwd_r0", {28'd0, fwd_a_a, fwd_b_a}, 32'd0);
        nc(); ex_rt = 9; wb_rd = 9; dm_rd = 9; dm_reg_write = 1; ne();
        pin("fwd_b_dm", {30'd0, fwd_b_a}, 32'd1);
        nc(); dm_access = 1; ne();
        pin("fwd_stalled", {30'd0, fwd_b_a}, 32'd0);
        nc(); idle(); repeat (3) nc();
        $display("txn forwarding");

        do_reset(); dm_access = 1;
        repeat (65540) nc();
        ne();
        pin("sat_a", {16'd0, stall_cnt_a}, 32'h0000FFFF);
        pin("sat_b", {16'd0, stall_cnt_b}, 32'h0000FFFF);
        $display("txn saturation");

        idle(); nc(); ne();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
